// File: rtl/cmd_arbiter_if.sv
// -----------------------------------------------------------------------------
// cmd_arbiter_if
//   Bundle for the command arbiter. It carries the N_REQ requester command
//   channels in, and the single arbitrated command strobe plus ownership
//   status out.
//   slave  : arbiter side. Requester fields are inputs; ready, command, grant
//            and locked are outputs.
//   master : requester/controller side. The same signals with directions
//            reversed.
// -----------------------------------------------------------------------------
interface cmd_arbiter_if #(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [N_REQ-1:0]                 req_valid_i;
    logic [N_REQ-1:0]                 req_lock_i;
    logic [N_REQ-1:0][ADDR_WIDTH-1:0] req_addr_i;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data_i;
    logic [N_REQ-1:0]                 req_ready_o;
    logic                             cmd_valid_o;
    logic [ADDR_WIDTH-1:0]            cmd_addr_o;
    logic [DATA_WIDTH-1:0]            cmd_data_o;
    logic [N_REQ-1:0]                 grant_o;
    logic                             locked_o;

    modport slave (
        input  req_valid_i, req_lock_i, req_addr_i, req_data_i,
        output req_ready_o, cmd_valid_o, cmd_addr_o, cmd_data_o, grant_o, locked_o
    );

    modport master (
        output req_valid_i, req_lock_i, req_addr_i, req_data_i,
        input  req_ready_o, cmd_valid_o, cmd_addr_o, cmd_data_o, grant_o, locked_o
    );
endinterface

// File: rtl/cmd_arbiter.sv
// -----------------------------------------------------------------------------
// cmd_arbiter
//   Round-robin arbiter that merges N_REQ command requesters onto one register
//   write strobe. A requester can hold ownership across several beats by
//   raising req_lock_i. The hold ends when it drops lock on a beat, when it
//   reaches MAX_LOCK beats, or when it goes quiet for IDLE_TIMEOUT cycles.
//   Ports:
//     clk_i    : clock; all state updates on the rising edge
//     rst_n_i  : synchronous active-low reset
//     bus      : cmd_arbiter_if.slave. It carries the requester valid, lock,
//                addr and data in, and ready, cmd_valid/addr/data, grant and
//                locked out.
// -----------------------------------------------------------------------------
module cmd_arbiter #(
    parameter int N_REQ        = 2,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_LOCK     = 16,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    cmd_arbiter_if.slave  bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         last_q, owner_q;
    logic [7:0]            beat_q, idle_q;
    logic                  cmd_valid_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [DATA_WIDTH-1:0] cmd_data_q;

    // Round-robin pick. Scan from last_q+1 and wrap. last_q is the last
    // requester to transfer.
    logic          sel_found;
    logic [IW-1:0] sel_idx, cand;
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last_q) + k) % N_REQ);
            if (!sel_found && bus.req_valid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // When the quiet counter hits the limit, the owner loses the lock on the
    // next edge. Its ready is withheld in that cycle so that no beat slips out.
    logic       timeout;
    logic [N_REQ-1:0] ready, grant;
    assign timeout = (idle_q >= 8'(IDLE_TIMEOUT));

    // Output logic: ready and grant.
    always_comb begin
        ready = '0;
        grant = '0;
        if (rst_n_i) begin
            if (state_q == IDLE) begin
                if (sel_found) begin
                    grant[sel_idx] = 1'b1;
                    ready[sel_idx] = 1'b1;
                end
            end else begin
                grant[owner_q] = 1'b1;
                if (bus.req_valid_i[owner_q] && !timeout)
                    ready[owner_q] = 1'b1;
            end
        end
    end

    logic          xfer, xfer_lock;
    logic [IW-1:0] xfer_idx;
    logic [7:0]    beat_inc;
    assign xfer      = |(ready & bus.req_valid_i);
    assign xfer_idx  = (state_q == IDLE) ? sel_idx : owner_q;
    assign xfer_lock = bus.req_lock_i[xfer_idx];
    assign beat_inc  = (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (xfer && xfer_lock && (MAX_LOCK > 1))
                    state_d = LOCKED;
            end
            LOCKED: begin
                if (timeout)
                    state_d = IDLE;
                else if (xfer && (!xfer_lock || beat_inc >= 8'(MAX_LOCK)))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Datapath and counters. last_q tracks every transfer. On release the
    // owner was therefore the last to move, so the scan restarts at owner+1.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_q      <= IW'(N_REQ - 1);
            owner_q     <= '0;
            beat_q      <= '0;
            idle_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
        end else begin
            cmd_valid_q <= xfer;
            if (xfer) begin
                last_q     <= xfer_idx;
                cmd_addr_q <= bus.req_addr_i[xfer_idx];
                cmd_data_q <= bus.req_data_i[xfer_idx];
            end
            if (state_q == IDLE) begin
                if (state_d == LOCKED) begin
                    owner_q <= xfer_idx;
                    beat_q  <= 8'd1;
                    idle_q  <= '0;
                end
            end else if (state_d == IDLE) begin
                beat_q <= '0;
                idle_q <= '0;
            end else if (xfer) begin
                beat_q <= beat_inc;
                idle_q <= '0;
            end else if (!bus.req_valid_i[owner_q]) begin
                idle_q <= idle_q + 8'd1;
            end
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.grant_o     = grant;
    assign bus.locked_o    = (state_q == LOCKED);
    assign bus.cmd_valid_o = cmd_valid_q;
    assign bus.cmd_addr_o  = cmd_addr_q;
    assign bus.cmd_data_o  = cmd_data_q;
endmodule

// File: tb/tb_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cmd_arbiter
//   Two arbiters driven side by side. Instance 0 uses MAX_LOCK=16 and
//   IDLE_TIMEOUT=8. Instance 1 uses MAX_LOCK=4 and IDLE_TIMEOUT=64.
//   Every cycle, each output is compared against a reference model written
//   from the arbitration rules. Directed scenarios add checks against fixed
//   expected values. A random phase follows the directed scenarios.
// -----------------------------------------------------------------------------
module tb_cmd_arbiter;
    localparam int N   = 2;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int ML0 = 16, TO0 = 8;
    localparam int ML1 = 4,  TO1 = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [1:0][N-1:0]         v, lk, rdy, gnt;
    logic [1:0][N-1:0][AW-1:0] a;
    logic [1:0][N-1:0][DW-1:0] dd;
    logic [1:0]                cv, lkd;
    logic [1:0][AW-1:0]        ca;
    logic [1:0][DW-1:0]        cd;

    cmd_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    cmd_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.req_valid_i = v[0];
    assign bus0.req_lock_i  = lk[0];
    assign bus0.req_addr_i  = a[0];
    assign bus0.req_data_i  = dd[0];
    assign rdy[0] = bus0.req_ready_o;
    assign gnt[0] = bus0.grant_o;
    assign lkd[0] = bus0.locked_o;
    assign cv[0]  = bus0.cmd_valid_o;
    assign ca[0]  = bus0.cmd_addr_o;
    assign cd[0]  = bus0.cmd_data_o;

    assign bus1.req_valid_i = v[1];
    assign bus1.req_lock_i  = lk[1];
    assign bus1.req_addr_i  = a[1];
    assign bus1.req_data_i  = dd[1];
    assign rdy[1] = bus1.req_ready_o;
    assign gnt[1] = bus1.grant_o;
    assign lkd[1] = bus1.locked_o;
    assign cv[1]  = bus1.cmd_valid_o;
    assign ca[1]  = bus1.cmd_addr_o;
    assign cd[1]  = bus1.cmd_data_o;

    cmd_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .MAX_LOCK(ML0), .IDLE_TIMEOUT(TO0))
        u_dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus0));
    cmd_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .MAX_LOCK(ML1), .IDLE_TIMEOUT(TO1))
        u_dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus1));

    int checks = 0;
    int errors = 0;

    // Reference model. It tracks whether a lock session is open, who owns it,
    // how many beats the owner has sent, and how many quiet cycles have passed.
    int            m_lk[2], m_own[2], m_beats[2], m_quiet[2], m_last[2];
    logic          m_cv[2];
    logic [AW-1:0] m_ca[2];
    logic [DW-1:0] m_cd[2];

    // These hold what the DUT showed in the most recent step.
    logic [1:0][N-1:0] o_rdy, o_gnt;
    logic [1:0]        o_cv, o_lkd;
    logic [1:0][AW-1:0] o_ca;
    logic [1:0][DW-1:0] o_cd;

    function automatic int max_lock(int d);
        return (d == 0) ? ML0 : ML1;
    endfunction

    function automatic int tmo(int d);
        return (d == 0) ? TO0 : TO1;
    endfunction

    function automatic logic [N-1:0] onehot(int i);
        logic [N-1:0] r;
        r = '0;
        if (i >= 0) r[i] = 1'b1;
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(int d);
        m_lk[d] = 0; m_own[d] = 0; m_beats[d] = 0; m_quiet[d] = 0;
        m_last[d] = N - 1; m_cv[d] = 1'b0; m_ca[d] = '0; m_cd[d] = '0;
    endtask

    // One clock cycle. Inputs are set beforehand, just after the previous
    // edge. All outputs are compared at the falling edge. The model then
    // moves forward at the rising edge.
    task automatic step();
        int sel[2];
        logic [N-1:0] eg;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel[d] = -1;
            if (rst_n) begin
                if (m_lk[d] == 0) begin
                    for (int k = 1; k <= N; k++) begin
                        int idx;
                        idx = (m_last[d] + k) % N;
                        if (sel[d] < 0 && v[d][idx]) sel[d] = idx;
                    end
                end else if (v[d][m_own[d]] && m_quiet[d] < tmo(d)) begin
                    sel[d] = m_own[d];
                end
            end
            eg = !rst_n ? '0 : (m_lk[d] != 0) ? onehot(m_own[d]) : onehot(sel[d]);
            check($sformatf("d%0d ready", d),  rdy[d], onehot(sel[d]));
            check($sformatf("d%0d grant", d),  gnt[d], eg);
            check($sformatf("d%0d locked", d), lkd[d], m_lk[d] != 0);
            check($sformatf("d%0d cmd_valid", d), cv[d], m_cv[d]);
            check($sformatf("d%0d cmd_addr", d),  ca[d], m_ca[d]);
            check($sformatf("d%0d cmd_data", d),  cd[d], m_cd[d]);
            o_rdy[d] = rdy[d]; o_gnt[d] = gnt[d]; o_cv[d] = cv[d];
            o_lkd[d] = lkd[d]; o_ca[d] = ca[d];   o_cd[d] = cd[d];
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                model_reset(d);
            end else begin
                m_cv[d] = (sel[d] >= 0);
                if (sel[d] >= 0) begin
                    m_ca[d] = a[d][sel[d]];
                    m_cd[d] = dd[d][sel[d]];
                    m_last[d] = sel[d];
                end
                if (m_lk[d] == 0) begin
                    if (sel[d] >= 0 && lk[d][sel[d]] && max_lock(d) > 1) begin
                        m_lk[d] = 1; m_own[d] = sel[d]; m_beats[d] = 1; m_quiet[d] = 0;
                    end
                end else if (m_quiet[d] >= tmo(d)) begin
                    m_lk[d] = 0;
                end else if (sel[d] >= 0) begin
                    m_beats[d]++;
                    m_quiet[d] = 0;
                    if (!lk[d][sel[d]] || m_beats[d] >= max_lock(d)) m_lk[d] = 0;
                end else begin
                    m_quiet[d]++;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        v = '0; lk = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; v = '0; lk = '0; a = '0; dd = '0;
        @(posedge clk); #1;
        model_reset(0);
        model_reset(1);

        // Reset state.
        step(); step();
        check("rst locked", o_lkd[0], 1'b0);
        check("rst cmd_valid", o_cv[1], 1'b0);
        rst_n = 1'b1;

        // Two requesters, no lock: grants alternate 0,1,0,1.
        v[0] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("alt ready %0d", i), o_rdy[0], (i % 2) ? 2'b10 : 2'b01);
            check($sformatf("alt cmd_valid %0d", i), o_cv[0], i > 0);
        end
        v[0] = '0;
        step();
        check("alt tail cmd_valid", o_cv[0], 1'b1);

        // req1 sends a 9-beat locked burst while req0 stays valid.
        do_reset();
        v[0] = 2'b01; step();          // req0 moves once, so req1 is scanned first
        v[0] = 2'b11; lk[0] = 2'b10; a[0][1] = AW'(16'h20);
        for (int n = 0; n < 9; n++) begin
            step();
            check($sformatf("burst ready %0d", n), o_rdy[0], 2'b10);
            a[0][1]  = AW'(16'h20 + n + 1);
            lk[0][1] = (n + 2 <= 8);
        end
        v[0][1] = 1'b0; lk[0] = '0;
        step();
        check("burst release ready", o_rdy[0], 2'b01);
        check("burst last addr", o_ca[0], 16'h28);
        check("burst last valid", o_cv[0], 1'b1);

        // MAX_LOCK=4: forced release after 4 beats, then req1, then req0 again.
        do_reset();
        v[1] = 2'b11; lk[1] = 2'b01;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("force ready %0d", i), o_rdy[1], (i == 4) ? 2'b10 : 2'b01);
        end
        for (int i = 0; i < 6; i++) step();
        lk[1] = '0;
        step(); step();

        // Idle timeout: req0 locks, then goes quiet while req1 waits.
        do_reset();
        v[0] = 2'b01; lk[0] = 2'b01; step();
        v[0] = 2'b10; lk[0] = '0;
        for (int i = 1; i <= 9; i++) begin
            step();
            check($sformatf("tmo locked %0d", i), o_lkd[0], 1'b1);
            check($sformatf("tmo ready %0d", i), o_rdy[0], 2'b00);
            check($sformatf("tmo cmd_valid %0d", i), o_cv[0], i == 1);
        end
        step();
        check("tmo released", o_lkd[0], 1'b0);
        check("tmo req1 ready", o_rdy[0], 2'b10);

        // Reset asserted mid-lock while a beat is in flight.
        do_reset();
        v[0] = 2'b01; lk[0] = 2'b01; step(); step();
        v[0] = 2'b11; rst_n = 1'b0;
        step();
        check("mid rst ready", o_rdy[0], 2'b00);
        check("mid rst inflight", o_cv[0], 1'b1);
        step();
        check("post rst cmd_valid", o_cv[0], 1'b0);
        check("post rst locked", o_lkd[0], 1'b0);
        check("post rst grant", o_gnt[0], 2'b00);
        rst_n = 1'b1;
        step();
        check("post rst first grant", o_rdy[0], 2'b01);

        // Data path: the beat appears for one cycle, then holds.
        do_reset();
        v[0] = 2'b01; a[0][0] = 16'h0050; dd[0][0] = 32'h0000_00A5;
        step();
        v[0] = '0; a[0][0] = 16'h1234; dd[0][0] = 32'hDEAD_BEEF;
        step();
        check("data valid", o_cv[0], 1'b1);
        check("data addr", o_ca[0], 16'h0050);
        check("data data", o_cd[0], 32'h0000_00A5);
        step();
        check("data hold valid", o_cv[0], 1'b0);
        check("data hold addr", o_ca[0], 16'h0050);
        check("data hold data", o_cd[0], 32'h0000_00A5);

        // Random traffic on both instances, with an occasional reset.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            for (int d = 0; d < 2; d++) begin
                for (int r = 0; r < N; r++) begin
                    v[d][r]  = ($urandom_range(0, 3) != 0);
                    lk[d][r] = ($urandom_range(0, 3) != 0);
                    a[d][r]  = AW'($urandom);
                    dd[d][r] = $urandom;
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
